prim_flop_nsync_filt: RTL

//  Parametrised multi-bit synchronizer: Stages-deep flop chain per bit, then an

---
 rtl/prim_sync_pkg.sv | 13 +
 rtl/prim_filter_ctr.sv | 87 ++++++++
 rtl/prim_flop_nsync_filt.sv | 75 +++++++
 3 files changed

// File: rtl/prim_sync_pkg.sv
// Shared definitions for the multi-bit synchronizer / glitch filter.
//   PRIM_SYNC_MIN_STAGES : smallest legal synchronizer depth
//   filt_cnt_w(f)        : width of the per-bit stability counter for a
//                          filter length of f cycles (at least 1 bit)
package prim_sync_pkg;

  localparam int unsigned PRIM_SYNC_MIN_STAGES = 2;

  function automatic int unsigned filt_cnt_w(input int unsigned f);
    return (f < 2) ? 1 : $clog2(f + 1);
  endfunction

endpackage

// File: rtl/prim_filter_ctr.sv
// One-bit glitch filter plus edge detector.
//   clk_i     in  1  clock
//   rst_ni    in  1  synchronous active-low reset
//   sync_i    in  1  already-synchronized input bit
//   rst_val_i in  1  value q_o takes in reset
//   q_o       out 1  filtered value
//   rise_o    out 1  one-cycle pulse when q_o goes 0->1
//   fall_o    out 1  one-cycle pulse when q_o goes 1->0
// With FilterCycles == 0 q_o simply registers sync_i. Otherwise sync_i must
// differ from q_o for FilterCycles consecutive cycles before q_o follows.
module prim_filter_ctr
  import prim_sync_pkg::*;
#(
  parameter int unsigned FilterCycles = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  input  logic rst_val_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic r_q;
  logic r_rise;
  logic r_fall;
  logic w_q_nxt;

  if (FilterCycles == 0) begin : g_nofilt

    always_comb begin
      w_q_nxt = sync_i;
    end

  end else begin : g_filt

    localparam int unsigned    CntW    = filt_cnt_w(FilterCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;

    // Any cycle where sync agrees with q_o restarts the stability count,
    // so pulses shorter than FilterCycles never reach q_o.
    always_comb begin
      w_cnt_nxt = r_cnt;
      w_q_nxt   = r_q;
      if (sync_i == r_q) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CntLast) begin
        w_q_nxt   = sync_i;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end

  end

  // Reset forces q_o without going through the edge logic, so a
  // reset-induced change never produces a pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q    <= rst_val_i;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_rise <= ~r_q & w_q_nxt;
      r_fall <= r_q & ~w_q_nxt;
    end
  end

  assign q_o    = r_q;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/prim_flop_nsync_filt.sv
// Parametrised multi-bit synchronizer with optional per-bit glitch filter
// and per-bit rise/fall pulses. Bits are fully independent; not suitable for
// buses whose bits must change coherently.
//   clk_i   in  1      clock
//   rst_ni  in  1      synchronous active-low reset
//   d_i     in  Width  asynchronous inputs
//   q_o     out Width  synchronized, filtered value
//   rise_o  out Width  one-cycle pulse per bit when q_o goes 0->1
//   fall_o  out Width  one-cycle pulse per bit when q_o goes 1->0
module prim_flop_nsync_filt
  import prim_sync_pkg::*;
#(
  parameter int unsigned      Width        = 16,
  parameter int unsigned      Stages       = 2,
  parameter int unsigned      FilterCycles = 0,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  if (Stages < PRIM_SYNC_MIN_STAGES) begin : g_chk_stages
    $error("prim_flop_nsync_filt: Stages must be at least 2");
  end

  if (Width < 1) begin : g_chk_width
    $error("prim_flop_nsync_filt: Width must be at least 1");
  end

  // Without a filter the output register of the filter cell is itself the
  // last synchronizer stage, keeping d_i->q_o latency at exactly Stages.
  // With a filter the full chain precedes it and latency is Stages+F.
  localparam int unsigned ChainD = (FilterCycles == 0) ? Stages - 1 : Stages;

  for (genvar k = 0; k < ChainD; k++) begin : g_stage
    logic [Width-1:0] r_q;
    logic [Width-1:0] w_in;

    if (k == 0) begin : g_first
      assign w_in = d_i;
    end else begin : g_next
      assign w_in = g_stage[k-1].r_q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_q <= ResetValue;
      end else begin
        r_q <= w_in;
      end
    end
  end

  logic [Width-1:0] w_sync;
  assign w_sync = g_stage[ChainD-1].r_q;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    prim_filter_ctr #(
      .FilterCycles(FilterCycles)
    ) u_filt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sync_i   (w_sync[i]),
      .rst_val_i(ResetValue[i]),
      .q_o      (q_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i])
    );
  end

endmodule
